// File: rtl/imem_loader_responder_pkg.sv
// Shared types and constants for the instruction-memory responder and its boot loader.
package imem_loader_responder_pkg;

    typedef enum logic [1:0] {LOAD_LO, LOAD_HI, DRAIN, RUN} imem_state_t;

    localparam int DATA_WIDTH = 16;
    localparam logic [DATA_WIDTH-1:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/imem_loader_responder_if.sv
// Fetch ports and byte-wide load stream between the core/loader and the instruction memory.
interface imem_loader_responder_if;
    import imem_loader_responder_pkg::*;

    logic [DATA_WIDTH-1:0] address_1;
    logic [DATA_WIDTH-1:0] address_2;
    logic [DATA_WIDTH-1:0] read_address_1;
    logic [DATA_WIDTH-1:0] read_address_2;
    logic                  load_valid;
    logic                  load_ready;
    logic [7:0]            load_data;
    logic                  load_last;

    modport slave (
        input  address_1, address_2, load_valid, load_data, load_last,
        output read_address_1, read_address_2, load_ready
    );

    modport master (
        output address_1, address_2, load_valid, load_data, load_last,
        input  read_address_1, read_address_2, load_ready
    );
endinterface

// File: rtl/imem_loader_responder_array.sv
// Word array: one synchronous write port, two combinational read ports; contents survive reset.
module imem_loader_responder_array
    import imem_loader_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
endmodule

// File: rtl/imem_loader_responder.sv
// Instruction memory with boot loader: packs a little-endian byte stream into words,
// holds the core in reset until the image is complete, then serves two fetch ports.
module imem_loader_responder
    import imem_loader_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_loader_responder_if.slave bus,
    input  logic                  load_restart,
    output logic                  core_hold,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_FILL = (ADDR_WIDTH+1)'(DEPTH - 1);

    imem_state_t           state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic                  hold_q;
    logic                  err_q;
    logic [7:0]            lo_q;

    logic                  hs;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;

    assign bus.load_ready = (state_q != RUN);
    assign hs             = bus.load_valid && (state_q != RUN);

    // The write happens on the accepting edge itself, so the word is in place before hold drops.
    assign we    = hs && ((state_q == LOAD_HI) || ((state_q == LOAD_LO) && bus.load_last));
    assign wdata = (state_q == LOAD_HI) ? {bus.load_data, lo_q} : {8'h00, bus.load_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD_LO;
            wr_ptr_q <= '0;
            words_q  <= '0;
            hold_q   <= 1'b1;
            err_q    <= 1'b0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                LOAD_LO: if (hs) begin
                    lo_q <= bus.load_data;
                    if (bus.load_last) begin
                        words_q <= words_q + 1'b1;
                        state_q <= RUN;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= LOAD_HI;
                    end
                end
                LOAD_HI: if (hs) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    words_q  <= words_q + 1'b1;
                    if (bus.load_last) begin
                        state_q <= RUN;
                        hold_q  <= 1'b0;
                    end else if (words_q == LAST_FILL) begin
                        state_q <= DRAIN;
                    end else begin
                        state_q <= LOAD_LO;
                    end
                end
                DRAIN: if (hs) begin
                    err_q <= 1'b1;
                    if (bus.load_last) begin
                        state_q <= RUN;
                        hold_q  <= 1'b0;
                    end
                end
                RUN: if (load_restart) begin
                    state_q  <= LOAD_LO;
                    wr_ptr_q <= '0;
                    words_q  <= '0;
                    hold_q   <= 1'b1;
                    err_q    <= 1'b0;
                end
                default: state_q <= LOAD_LO;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] addr_w [2];
    logic [DATA_WIDTH-1:0] raw_w  [2];
    logic [DATA_WIDTH-1:0] rd_w   [2];

    assign addr_w[0] = bus.address_1;
    assign addr_w[1] = bus.address_2;

    imem_loader_responder_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk      (clk),
        .we_i     (we),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (wdata),
        .raddr1_i (addr_w[0][ADDR_WIDTH-1:0]),
        .raddr2_i (addr_w[1][ADDR_WIDTH-1:0]),
        .rdata1_o (raw_w[0]),
        .rdata2_o (raw_w[1])
    );

    // Masking while held also guarantees a fetch never races the loader's write.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic rd_ok;
            assign rd_ok = !hold_q
                        && (addr_w[gi][DATA_WIDTH-1:ADDR_WIDTH] == '0)
                        && ({1'b0, addr_w[gi][ADDR_WIDTH-1:0]} < words_q);
            assign rd_w[gi] = rd_ok ? raw_w[gi] : NOP_WORD;
        end
    endgenerate

    assign bus.read_address_1 = rd_w[0];
    assign bus.read_address_2 = rd_w[1];
    assign core_hold          = hold_q;
    assign load_error         = err_q;
    assign words_loaded       = words_q;
endmodule
